// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and sizes for the four-way round-robin arbiter.
package rr_arbiter_4_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter_4_dec.sv
// 2-to-4 one-hot decoder used to turn the registered owner index into a grant bus.
module decoder_2_4
  import rr_arbiter_4_pkg::*;
(
  input  logic [ID_W-1:0]  i_sel,
  output logic [N_REQ-1:0] o_onehot
);

  always_comb begin
    o_onehot        = '0;
    o_onehot[i_sel] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter: one owner at a time, released by done, request drop
// or hold timeout, always followed by one empty turnaround cycle.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_id,
  output logic             grant_valid,
  output logic             timeout
);

  localparam int HC_W = (MAX_HOLD <= 2) ? 1 : $clog2(MAX_HOLD);
  localparam logic [HC_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HC_W'(MAX_HOLD - 1);

  state_t           r_state, w_state;
  logic [ID_W-1:0]  r_ptr, w_ptr;
  logic [ID_W-1:0]  r_grant_id, w_grant_id;
  logic             r_grant_valid, w_grant_valid;
  logic             r_timeout, w_timeout;
  logic [HC_W-1:0]  r_hold_cnt, w_hold_cnt;
  logic             w_limit;
  logic             w_owner_req;
  logic [N_REQ-1:0] w_dec;

  // First set request bit scanning upward from p, wrapping modulo N_REQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] rq,
                                              input logic [ID_W-1:0]  p);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] win;
    logic            found;
    win   = p;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = p + ID_W'(i);
      if (!found && rq[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign w_limit     = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_LAST);
  assign w_owner_req = req[r_grant_id];

  always_comb begin
    w_state       = r_state;
    w_ptr         = r_ptr;
    w_grant_id    = r_grant_id;
    w_grant_valid = r_grant_valid;
    w_timeout     = 1'b0;
    w_hold_cnt    = r_hold_cnt;
    case (r_state)
      IDLE: begin
        if (|req) begin
          w_grant_id    = rr_pick(req, r_ptr);
          w_grant_valid = 1'b1;
          w_hold_cnt    = '0;
          w_state       = GRANT;
        end
      end
      GRANT: begin
        if (done || !w_owner_req || w_limit) begin
          w_grant_valid = 1'b0;
          w_ptr         = r_grant_id + 1'b1;
          w_state       = IDLE;
          // Only a pure hold-limit release is reported as a timeout.
          w_timeout     = w_limit && !done && w_owner_req;
        end else if (r_hold_cnt != HOLD_LAST) begin
          w_hold_cnt = r_hold_cnt + 1'b1;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_grant_id    <= '0;
      r_grant_valid <= 1'b0;
      r_timeout     <= 1'b0;
      r_hold_cnt    <= '0;
    end else begin
      r_state       <= w_state;
      r_ptr         <= w_ptr;
      r_grant_id    <= w_grant_id;
      r_grant_valid <= w_grant_valid;
      r_timeout     <= w_timeout;
      r_hold_cnt    <= w_hold_cnt;
    end
  end

  decoder_2_4 u_dec (
    .i_sel    (r_grant_id),
    .o_onehot (w_dec)
  );

  assign grant       = w_dec & {N_REQ{r_grant_valid}};
  assign grant_id    = r_grant_id;
  assign grant_valid = r_grant_valid;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4 (MAX_HOLD=4): directed vector table, async reset cases and
// randomized traffic against an owner/turn reference model.
module tb_rr_arbiter_4;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int n_chk  = 0;
  int n_pass = 0;

  rr_arbiter_4 #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] req;
    logic       done;
    logic [3:0] exp_grant;
    logic       exp_to;
  } vec_t;

  vec_t tbl [28];

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic cyc(input logic [3:0] r, input logic d);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] k;
    k = 2'd0;
    for (int i = 0; i < 4; i++) if (g[i]) k = 2'(i);
    return k;
  endfunction

  // Reference model: owner is -1 when idle, held counts visible grant cycles.
  int m_owner, m_ptr, m_held;
  logic m_to;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_held = 0; m_to = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] r, input logic d);
    logic lim;
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr + k) % 4;
        if (m_owner < 0 && r[c]) m_owner = c;
      end
      if (m_owner >= 0) m_held = 1;
    end else begin
      lim = (MH != 0) && (m_held == MH);
      if (d || !r[m_owner] || lim) begin
        m_to    = lim && !d && r[m_owner];
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end
  endtask

  initial begin
    logic [3:0] r;
    logic       d;
    logic [3:0] eg;

    tbl[0]  = '{4'b1111, 1'b0, 4'b0001, 1'b0};
    tbl[1]  = '{4'b1111, 1'b1, 4'b0000, 1'b0};
    tbl[2]  = '{4'b1111, 1'b0, 4'b0010, 1'b0};
    tbl[3]  = '{4'b1111, 1'b1, 4'b0000, 1'b0};
    tbl[4]  = '{4'b1111, 1'b0, 4'b0100, 1'b0};
    tbl[5]  = '{4'b1111, 1'b1, 4'b0000, 1'b0};
    tbl[6]  = '{4'b1111, 1'b0, 4'b1000, 1'b0};
    tbl[7]  = '{4'b1111, 1'b1, 4'b0000, 1'b0};
    tbl[8]  = '{4'b1010, 1'b0, 4'b0010, 1'b0};
    tbl[9]  = '{4'b1010, 1'b1, 4'b0000, 1'b0};
    tbl[10] = '{4'b1010, 1'b0, 4'b1000, 1'b0};
    tbl[11] = '{4'b1010, 1'b1, 4'b0000, 1'b0};
    tbl[12] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
    tbl[13] = '{4'b0000, 1'b0, 4'b0000, 1'b0};
    tbl[14] = '{4'b1111, 1'b0, 4'b1000, 1'b0};
    tbl[15] = '{4'b1111, 1'b1, 4'b0000, 1'b0};
    tbl[16] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
    tbl[17] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
    tbl[18] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
    tbl[19] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
    tbl[20] = '{4'b0100, 1'b0, 4'b0000, 1'b1};
    tbl[21] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
    tbl[22] = '{4'b0100, 1'b1, 4'b0000, 1'b0};
    tbl[23] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
    tbl[24] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
    tbl[25] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
    tbl[26] = '{4'b0100, 1'b0, 4'b0100, 1'b0};
    tbl[27] = '{4'b0100, 1'b1, 4'b0000, 1'b0};

    // Reset held with all requests active.
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant",   grant,             4'b0000);
    chk("rst_valid",   {3'b0, grant_valid}, 4'b0000);
    chk("rst_timeout", {3'b0, timeout},   4'b0000);
    chk("rst_id",      {2'b0, grant_id},  4'b0000);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      cyc(tbl[i].req, tbl[i].done);
      chk($sformatf("vec%0d_grant", i),   grant,               tbl[i].exp_grant);
      chk($sformatf("vec%0d_valid", i),   {3'b0, grant_valid}, {3'b0, |tbl[i].exp_grant});
      chk($sformatf("vec%0d_timeout", i), {3'b0, timeout},     {3'b0, tbl[i].exp_to});
      if (tbl[i].exp_grant != 4'b0000)
        chk($sformatf("vec%0d_id", i), {2'b0, grant_id}, {2'b0, idx_of(tbl[i].exp_grant)});
    end

    // Async reset between edges while id 3 owns the bus.
    cyc(4'b1111, 1'b0);
    chk("pre_async_grant", grant, 4'b1000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_grant", grant,               4'b0000);
    chk("async_rst_valid", {3'b0, grant_valid}, 4'b0000);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_grant", grant, 4'b0001);

    // Randomized traffic against the reference model.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) r = r | 4'($urandom_range(0, 15));
      d = ($urandom_range(0, 4) == 0);
      cyc(r, d);
      model_edge(r, d);
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      chk("rand_grant",   grant,               eg);
      chk("rand_timeout", {3'b0, timeout},     {3'b0, m_to});
      if (m_owner >= 0) chk("rand_id", {2'b0, grant_id}, 4'(m_owner));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-way round-robin arbiter that shares one resource between four requesters.
- Registers a 2-bit winner index and drives a one-hot grant bus through a 2-to-4 decoder.
- Sits in front of any shared datapath in the design (e.g. a common bus or ALU port).
- Each grant is held until the owner releases it or a hold-timeout expires.

Parameters:
- MAX_HOLD, 16: maximum number of consecutive cycles one owner may hold the grant. 0 disables the timeout. Legal values are 0 or 2..256.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request lines; bit i is requester i, level-sensitive.
- done  input  1  owner releases the grant; sampled only in GRANT.
- grant  output  4  one-hot grant, registered; all zero when no owner.
- grant_id  output  2  index of the current owner; valid when grant_valid=1.
- grant_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when the hold limit forces a release.

Behaviour:
- One clock domain (clk). Reset rst_n is asynchronous and active-low.
- Reset values:
  - state=IDLE, ptr=0, grant=4'b0000, grant_id=0.
  - grant_valid=0, timeout=0, hold_cnt=0.
  - Reset asserted mid-grant clears grant asynchronously. After reset, priority starts at requester 0.
- State IDLE:
  - If req != 0, the winner is the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - On that clock edge: grant_id<=winner, grant_valid<=1, hold_cnt<=0, state<=GRANT.
  - Latency is one cycle from req seen high to grant high.
  - If req == 0, remain in IDLE.
- State GRANT: release occurs when any of the following holds:
  - done=1, or
  - req[grant_id]=0, or
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
- On release:
  - grant_valid<=0, ptr<=grant_id+1 (mod 4), state<=IDLE.
  - timeout<=1 for one cycle only if the hold limit was the cause and neither done nor request drop was also true.
- No release: hold_cnt increments, saturating at MAX_HOLD-1.
- Grant spacing: every release is followed by at least one IDLE cycle with grant=0 (bus turnaround). Back-to-back grants are therefore spaced by exactly one empty cycle.
- grant = decode(grant_id) gated by grant_valid. It is combinational from registered state, so it is glitch-free relative to clk and never has more than one bit set.
- Simultaneous events:
  - done and the hold limit in the same cycle count as a normal release; timeout stays 0.
  - New req bits that arrive during GRANT are ignored until IDLE.
  - The owner's request dropping and reasserting in the release cycle has no effect; arbitration happens again in IDLE using the rotated ptr.
- Starvation bound: any continuously asserted request is granted within 4 grant periods.
- hold_cnt width is $clog2(MAX_HOLD), minimum 1 bit.

Decomposition:
- Shared package holds:
  - state enum (IDLE=1'b0, GRANT=1'b1)
  - N_REQ=4
  - ID_W=2
- Sub-module: the existing decoder_2_4 is instantiated once to convert grant_id to one-hot. The arbiter ANDs its output with grant_valid.
- Rotating-priority search stays inline as a small combinational function.

Test Plan:
- Reset: hold rst_n=0 with req=4'b1111, then release → grant=0000, grant_valid=0 through reset; first grant on the next edge is 0001 (id 0).
- Full rotation: req=4'b1111 held, done pulsed 1 cycle in each grant → grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
- Sparse requests: req=4'b1010 after a grant to id 3 → next grant is 0010 (id 1), then 1000 (id 3).
- Timeout: MAX_HOLD=4, req=4'b0100 held, done=0 → grant=0100 for exactly 4 cycles, timeout=1 in the cycle grant drops, re-grant to 0100 after one idle cycle.
- Request drop: grant id 2 active, req[2] falls → grant=0000 next cycle, timeout=0, ptr=3.
- Async reset mid-grant: grant=1000, assert rst_n=0 between clock edges → grant=0000 immediately, not at the next edge.
